// File: rtl/m_ifetch_queue.sv
// Instruction fetch front end: req/ack memory port feeding a small prefetch FIFO
// that presents {pc, inst} to decode; a redirect flushes the FIFO and restarts fetch.
module m_ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    output logic        w_mem_req,
    output logic [31:0] w_mem_addr,
    input  logic        w_mem_ack,
    input  logic [31:0] w_mem_rdata,
    output logic        w_inst_valid,
    output logic [31:0] w_inst,
    output logic [31:0] w_inst_pc,
    input  logic        w_inst_ready,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_req_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    entry_t          fifo_q [DEPTH];

    logic [XLEN-1:0]  redir_pc_c;
    logic [XLEN-1:0]  seq_pc_c;
    logic             mem_done_c;
    logic             pop_c;
    logic             push_c;
    logic [CNT_W-1:0] count_pop_c;
    logic [CNT_W-1:0] count_push_pop_c;

    assign redir_pc_c       = {w_redirect_pc[XLEN-1:2], 2'b00};
    assign seq_pc_c         = fetch_pc_q + XLEN'(4);
    assign mem_done_c       = mem_req_q & w_mem_ack;
    assign pop_c            = (count_q != '0) & w_inst_ready & ~w_redirect;
    assign count_pop_c      = count_q - CNT_W'(pop_c);
    assign count_push_pop_c = count_pop_c + CNT_W'(1);

    // State register and fetch address tracking
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= (state_d != S_IDLE);
        end
    end

    // Next-state logic; a redirect always wins, DROP waits out the stale transaction
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        push_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_redirect) begin
                    state_d    = S_FETCH;
                    fetch_pc_d = redir_pc_c;
                    mem_addr_d = redir_pc_c;
                end else if (count_pop_c < CNT_W'(DEPTH)) begin
                    state_d    = S_FETCH;
                    mem_addr_d = fetch_pc_q;
                end
            end
            S_FETCH: begin
                if (w_redirect) begin
                    fetch_pc_d = redir_pc_c;
                    if (mem_done_c) begin
                        mem_addr_d = redir_pc_c;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (mem_done_c) begin
                    push_c     = 1'b1;
                    fetch_pc_d = seq_pc_c;
                    if (count_push_pop_c < CNT_W'(DEPTH)) begin
                        mem_addr_d = seq_pc_c;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (w_redirect) begin
                    fetch_pc_d = redir_pc_c;
                end
                if (mem_done_c) begin
                    state_d    = S_FETCH;
                    mem_addr_d = w_redirect ? redir_pc_c : fetch_pc_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO occupancy and pointers; redirect flushes and drops any pending pop
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (w_redirect) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            wr_ptr_q <= wr_ptr_q + PTR_W'(push_c);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_c);
        end
    end

    // FIFO storage
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push_c) begin
            fifo_q[wr_ptr_q] <= '{pc: fetch_pc_q, inst: w_mem_rdata};
        end
    end

    assign w_mem_req    = mem_req_q;
    assign w_mem_addr   = mem_addr_q;
    assign w_inst_valid = (count_q != '0);
    assign w_inst       = fifo_q[rd_ptr_q].inst;
    assign w_inst_pc    = fifo_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Bench for m_ifetch_queue: queue-based reference model, variable-latency memory
// responder, and directed scenarios with literal expectations.
module tb_m_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_mem_ack = 1'b0;
    logic [31:0] w_mem_rdata = 32'h0;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_inst_ready = 1'b0;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;

    always #5 w_clk = ~w_clk;

    m_ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_mem_req     (w_mem_req),
        .w_mem_addr    (w_mem_addr),
        .w_mem_ack     (w_mem_ack),
        .w_mem_rdata   (w_mem_rdata),
        .w_inst_valid  (w_inst_valid),
        .w_inst        (w_inst),
        .w_inst_pc     (w_inst_pc),
        .w_inst_ready  (w_inst_ready),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];
    ent_t got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk_got(input string name, input int idx, input logic [31:0] pc);
        if (idx < got.size()) begin
            chk(name, got[idx].pc, pc);
            chk(name, got[idx].inst, word_of(pc));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s actual=missing(delivered=%0d) expected=pc %h", name, got.size(), pc);
        end
    endtask

    // Memory responder: ack after lat waiting cycles; optional stray ack when idle
    int unsigned lat    = 1;
    bit          stray  = 1'b0;
    int unsigned age    = 0;
    int          n_acks = 0;
    always @(posedge w_clk) begin
        if (w_rst_n && w_mem_req && w_mem_ack) n_acks++;
        #1;
        if (w_mem_req) begin
            if (age >= lat) begin
                w_mem_ack   = 1'b1;
                w_mem_rdata = word_of(w_mem_addr);
                age         = 0;
            end else begin
                w_mem_ack = 1'b0;
                age++;
            end
        end else begin
            w_mem_ack   = stray;
            w_mem_rdata = 32'hDEAD_BEEF;
            age         = 0;
        end
    end

    // Reference model: outstanding request, drop flag, next fetch pc, queue of entries
    logic        m_req  = 1'b0;
    logic [31:0] m_addr = RESET_PC;
    logic [31:0] m_pc   = RESET_PC;
    logic        m_drop = 1'b0;
    always @(posedge w_clk or negedge w_rst_n) begin : model
        logic [31:0] npc;
        logic        ack;
        logic        pop;
        if (!w_rst_n) begin
            m_req  = 1'b0;
            m_addr = RESET_PC;
            m_pc   = RESET_PC;
            m_drop = 1'b0;
            mq.delete();
        end else begin
            ack = m_req && w_mem_ack;
            pop = (mq.size() != 0) && w_inst_ready && !w_redirect;
            npc = w_redirect_pc & 32'hFFFF_FFFC;
            if (w_redirect) begin
                mq.delete();
                m_pc = npc;
                if (!m_req || ack) begin
                    m_req  = 1'b1;
                    m_addr = npc;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end else begin
                if (pop) void'(mq.pop_front());
                if (!m_req) begin
                    if (mq.size() < DEPTH) begin
                        m_req  = 1'b1;
                        m_addr = m_pc;
                    end
                end else if (ack) begin
                    if (m_drop) begin
                        m_drop = 1'b0;
                        m_addr = m_pc;
                    end else begin
                        mq.push_back(ent_t'({m_addr, w_mem_rdata}));
                        m_pc = m_addr + 32'd4;
                        if (mq.size() < DEPTH) m_addr = m_pc;
                        else m_req = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model; also logs what decode consumed
    bit chk_en = 1'b0;
    always @(negedge w_clk) begin
        if (chk_en && w_rst_n) begin
            chk("req", 32'(w_mem_req), 32'(m_req));
            if (m_req) chk("addr", w_mem_addr, m_addr);
            chk("valid", 32'(w_inst_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("inst_pc", w_inst_pc, mq[0].pc);
                chk("inst", w_inst, mq[0].inst);
            end
            if (w_inst_valid && w_inst_ready && !w_redirect) got.push_back(ent_t'({w_inst_pc, w_inst}));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge w_clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        w_redirect    = 1'b1;
        w_redirect_pc = pc;
        cyc(1);
        w_redirect = 1'b0;
    endtask

    initial begin : stim
        int base;
        int k;
        cyc(2);
        chk("rst_req", 32'(w_mem_req), 32'h0);
        chk("rst_addr", w_mem_addr, 32'h0);
        chk("rst_valid", 32'(w_inst_valid), 32'h0);
        chk("rst_inst", w_inst, 32'h0);
        chk("rst_inst_pc", w_inst_pc, 32'h0);
        w_rst_n = 1'b1;
        chk_en  = 1'b1;

        // Fill with decode stalled: exactly four fetches, then requests stop
        lat = 1;
        cyc(20);
        chk("full_acks", 32'(n_acks), 32'd4);
        chk("full_req", 32'(w_mem_req), 32'h0);
        chk("full_head_pc", w_inst_pc, 32'h0);
        chk("full_head_inst", w_inst, 32'hC0DE_0000);
        stray = 1'b1;
        cyc(4);
        stray = 1'b0;
        chk("stray_acks", 32'(n_acks), 32'd4);
        chk("stray_req", 32'(w_mem_req), 32'h0);

        // Release decode: in-order, no loss or duplication, fetch resumes at 16
        w_inst_ready = 1'b1;
        cyc(20);
        for (int i = 0; i < 6; i++) chk_got("order", i, 32'(i * 4));
        chk("order_inst4", got[4].inst, 32'hC0DE_0010);

        // Redirect from IDLE with entries held
        w_inst_ready = 1'b0;
        cyc(20);
        chk("pre_t3_req", 32'(w_mem_req), 32'h0);
        chk("pre_t3_valid", 32'(w_inst_valid), 32'h1);
        base = got.size();
        redirect_to(32'h40);
        chk("t3_valid", 32'(w_inst_valid), 32'h0);
        chk("t3_req", 32'(w_mem_req), 32'h1);
        chk("t3_addr", w_mem_addr, 32'h40);
        w_inst_ready = 1'b1;
        cyc(15);
        chk_got("t3_first", base, 32'h40);
        chk_got("t3_second", base + 1, 32'h44);

        // Redirect while a slow request is outstanding
        w_inst_ready = 1'b0;
        cyc(20);
        lat = 3;
        w_inst_ready = 1'b1;
        redirect_to(32'h10);
        chk("t4_addr0", w_mem_addr, 32'h10);
        base = got.size();
        redirect_to(32'h80);
        chk("t4_hold_req", 32'(w_mem_req), 32'h1);
        chk("t4_hold_addr", w_mem_addr, 32'h10);
        k = 0;
        while (w_mem_addr == 32'h10 && k < 20) begin
            cyc(1);
            k++;
        end
        chk("t4_new_addr", w_mem_addr, 32'h80);
        chk("t4_discard", 32'(w_inst_valid), 32'h0);
        cyc(30);
        chk_got("t4_first", base, 32'h80);

        // Redirect coinciding with an ack; misaligned target
        lat = 0;
        cyc(3);
        #1;
        k = 0;
        while (!(w_mem_req && w_mem_ack) && k < 20) begin
            @(posedge w_clk);
            #2;
            k++;
        end
        chk("t5_ack_seen", 32'(w_mem_req && w_mem_ack), 32'h1);
        base = got.size();
        w_redirect    = 1'b1;
        w_redirect_pc = 32'h43;
        @(posedge w_clk);
        #1;
        w_redirect = 1'b0;
        chk("t5_req", 32'(w_mem_req), 32'h1);
        chk("t5_addr", w_mem_addr, 32'h40);
        cyc(10);
        chk_got("t5_first", base, 32'h40);

        // Fetch pc wraps modulo 2^32
        base = got.size();
        redirect_to(32'hFFFF_FFF8);
        cyc(10);
        chk_got("wrap0", base, 32'hFFFF_FFF8);
        chk_got("wrap1", base + 1, 32'hFFFF_FFFC);
        chk_got("wrap2", base + 2, 32'h0000_0000);

        // Asynchronous reset mid-transaction
        lat = 3;
        cyc(2);
        @(posedge w_clk);
        #3;
        w_rst_n = 1'b0;
        #1;
        chk("ar_req", 32'(w_mem_req), 32'h0);
        chk("ar_valid", 32'(w_inst_valid), 32'h0);
        chk("ar_addr", w_mem_addr, RESET_PC);
        chk("ar_inst", w_inst, 32'h0);
        chk("ar_inst_pc", w_inst_pc, 32'h0);
        cyc(2);
        #2;
        w_rst_n = 1'b1;
        lat     = 1;
        base    = got.size();
        cyc(20);
        for (int i = 0; i < 4; i++) chk_got("ar_restart", base + i, 32'(i * 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
